// File: rtl/washing_machine_ctrl.sv
// Wash-cycle sequencer: steps through fill/wash/drain/rinse/spin or dry phases,
// each held for a fixed number of clocks, with pause, door interlock and stop.
module washing_machine_ctrl #(
    parameter logic [15:0] FILL_T  = 16'd5,
    parameter logic [15:0] WASH_T  = 16'd20,
    parameter logic [15:0] DRAIN_T = 16'd5,
    parameter logic [15:0] RINSE_T = 16'd10,
    parameter logic [15:0] SPIN_T  = 16'd10,
    parameter logic [15:0] DRY_T   = 16'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        doorclosed,
    input  logic        detergentfilled,
    input  logic        dry,
    input  logic        washOnly,
    input  logic [1:0]  waterTemp,
    input  logic [1:0]  spinSpeed,
    output logic        doorLock,
    output logic        motorStart,
    output logic [1:0]  motor_speed,
    output logic [1:0]  heater_on,
    output logic        fill_value_on,
    output logic        soap_value_on,
    output logic        drain_value_on,
    output logic        soapWash,
    output logic        waterWash,
    output logic        cycleFinished,
    output logic        rinseFinished,
    output logic        spinFinished,
    output logic        done,
    output logic        alarm,
    output logic [15:0] timer
);

    typedef enum logic [3:0] {
        IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DRY, DONE
    } state_t;

    state_t state;
    state_t next_phase;
    logic   wash_only_q;
    logic   start_ok;
    logic   running;
    logic   hold;
    logic   last;

    function automatic logic [15:0] phase_len(input state_t s);
        case (s)
            FILL_W, FILL_R:   phase_len = FILL_T;
            WASH:             phase_len = WASH_T;
            DRAIN_W, DRAIN_R: phase_len = DRAIN_T;
            RINSE:            phase_len = RINSE_T;
            SPIN:             phase_len = SPIN_T;
            DRY:              phase_len = DRY_T;
            default:          phase_len = 16'd0;
        endcase
    endfunction

    assign start_ok = doorclosed && (dry || detergentfilled);
    assign running  = (state != IDLE) && (state != DONE);
    assign hold     = pause || !doorclosed;
    assign last     = running && !hold && (timer == 16'd1);

    // Successor of the current phase; wash-only programs finish after the first drain.
    always_comb begin
        next_phase = DONE;
        case (state)
            FILL_W:  next_phase = WASH;
            WASH:    next_phase = DRAIN_W;
            DRAIN_W: next_phase = wash_only_q ? DONE : FILL_R;
            FILL_R:  next_phase = RINSE;
            RINSE:   next_phase = DRAIN_R;
            DRAIN_R: next_phase = SPIN;
            default: next_phase = DONE;
        endcase
    end

    // State and phase countdown; stop outranks every other condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= 16'd0;
            wash_only_q <= 1'b0;
        end else if (stop) begin
            state <= IDLE;
            timer <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && start_ok) begin
                        wash_only_q <= washOnly && !dry;
                        state       <= dry ? DRY : FILL_W;
                        timer       <= dry ? DRY_T : FILL_T;
                    end
                end
                DONE: begin
                    if (!start) state <= IDLE;
                end
                default: begin
                    if (!hold) begin
                        if (timer == 16'd1) begin
                            state <= next_phase;
                            timer <= phase_len(next_phase);
                        end else begin
                            timer <= timer - 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Actuator decode; a held phase (pause or open door) keeps only the door lock.
    always_comb begin
        doorLock       = running;
        motorStart     = 1'b0;
        motor_speed    = 2'b00;
        heater_on      = 2'b00;
        fill_value_on  = 1'b0;
        soap_value_on  = 1'b0;
        drain_value_on = 1'b0;
        soapWash       = 1'b0;
        waterWash      = 1'b0;
        cycleFinished  = last && (state == WASH);
        rinseFinished  = last && (state == RINSE);
        spinFinished   = last && (state == SPIN);
        done           = (state == DONE);
        alarm          = ((state == IDLE) && start && !start_ok) || (running && !doorclosed);
        if (running && !hold) begin
            case (state)
                FILL_W: begin
                    fill_value_on = 1'b1;
                    soap_value_on = 1'b1;
                end
                WASH: begin
                    motorStart  = 1'b1;
                    motor_speed = 2'b01;
                    soapWash    = 1'b1;
                    heater_on   = waterTemp;
                end
                FILL_R: fill_value_on = 1'b1;
                RINSE: begin
                    motorStart  = 1'b1;
                    motor_speed = 2'b01;
                    waterWash   = 1'b1;
                end
                DRAIN_W, DRAIN_R: drain_value_on = 1'b1;
                SPIN: begin
                    motorStart     = 1'b1;
                    drain_value_on = 1'b1;
                    motor_speed    = (spinSpeed == 2'b00) ? 2'b01 : spinSpeed;
                end
                DRY: begin
                    motorStart  = 1'b1;
                    motor_speed = 2'b10;
                    heater_on   = 2'b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Directed bench for washing_machine_ctrl: per-cycle checks of the packed output
// word {timer, doorLock, motorStart, motor_speed, heater_on, valves, flags, done, alarm}.
module tb_washing_machine_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, pause, doorclosed, detergentfilled, dry, washOnly;
    logic [1:0]  waterTemp, spinSpeed;
    logic        doorLock, motorStart, fill_value_on, soap_value_on, drain_value_on;
    logic        soapWash, waterWash, cycleFinished, rinseFinished, spinFinished, done, alarm;
    logic [1:0]  motor_speed, heater_on;
    logic [15:0] timer;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected output words, bit 15 = doorLock ... bit 0 = alarm
    localparam logic [15:0] O_IDLE  = 16'h0000;
    localparam logic [15:0] O_FILLW = 16'h8300;
    localparam logic [15:0] O_WASH  = 16'hD440;
    localparam logic [15:0] O_DRAIN = 16'h8080;
    localparam logic [15:0] O_FILLR = 16'h8200;
    localparam logic [15:0] O_RINSE = 16'hD020;
    localparam logic [15:0] O_SPIN  = 16'hE080;
    localparam logic [15:0] O_DRY   = 16'hEC00;
    localparam logic [15:0] O_DONE  = 16'h0002;
    localparam logic [15:0] O_HELD  = 16'h8000;
    localparam logic [15:0] O_DOOR  = 16'h8001;
    localparam logic [15:0] O_ALARM = 16'h0001;
    localparam logic [15:0] P_CF    = 16'h0010;
    localparam logic [15:0] P_RF    = 16'h0008;
    localparam logic [15:0] P_SF    = 16'h0004;

    always #5 clk = ~clk;

    washing_machine_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .doorclosed(doorclosed), .detergentfilled(detergentfilled), .dry(dry),
        .washOnly(washOnly), .waterTemp(waterTemp), .spinSpeed(spinSpeed),
        .doorLock(doorLock), .motorStart(motorStart), .motor_speed(motor_speed),
        .heater_on(heater_on), .fill_value_on(fill_value_on), .soap_value_on(soap_value_on),
        .drain_value_on(drain_value_on), .soapWash(soapWash), .waterWash(waterWash),
        .cycleFinished(cycleFinished), .rinseFinished(rinseFinished),
        .spinFinished(spinFinished), .done(done), .alarm(alarm), .timer(timer)
    );

    function automatic logic [31:0] obs();
        obs = {timer, doorLock, motorStart, motor_speed, heater_on, fill_value_on,
               soap_value_on, drain_value_on, soapWash, waterWash, cycleFinished,
               rinseFinished, spinFinished, done, alarm};
    endfunction

    // Inputs change and outputs are sampled mid-cycle, away from the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; doorclosed = 1; detergentfilled = 1;
        dry = 0; washOnly = 0; waterTemp = 2'b01; spinSpeed = 2'b10;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL reset: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        rst_n = 1;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL reset_idle: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
    endtask

    task automatic test_normal();
        logic [15:0] lens [7] = '{16'd5, 16'd20, 16'd5, 16'd5, 16'd10, 16'd5, 16'd10};
        logic [15:0] outs [7] = '{O_FILLW, O_WASH, O_DRAIN, O_FILLR, O_RINSE, O_DRAIN, O_SPIN};
        logic [15:0] puls [7] = '{16'h0, P_CF, 16'h0, 16'h0, P_RF, 16'h0, P_SF};
        logic [15:0] exp_o;
        int clk_no = 0;
        idle_inputs();
        start = 1;
        for (int p = 0; p < 7; p++) begin
            for (int t = int'(lens[p]); t >= 1; t--) begin
                tick();
                clk_no++;
                exp_o = outs[p] | ((t == 1) ? puls[p] : 16'h0);
                n_checks++;
                if (obs() !== {16'(t), exp_o})
                    $display("FAIL normal clk%0d: got %h expected %h", clk_no, obs(), {16'(t), exp_o});
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_DONE}) $display("FAIL normal_done: got %h expected %h", obs(), {16'd0, O_DONE});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_DONE}) $display("FAIL done_hold: got %h expected %h", obs(), {16'd0, O_DONE});
        else n_pass++;
        start = 0;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL done_to_idle: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
    endtask

    task automatic test_pause();
        idle_inputs();
        start = 1;
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (obs() !== {16'd12, O_WASH}) $display("FAIL pause_pre: got %h expected %h", obs(), {16'd12, O_WASH});
        else n_pass++;
        waterTemp = 2'b11;
        #1;
        n_checks++;
        if (obs() !== {16'd12, 16'hDC40}) $display("FAIL heater_live: got %h expected %h", obs(), {16'd12, 16'hDC40});
        else n_pass++;
        waterTemp = 2'b01;
        pause = 1;
        #1;
        n_checks++;
        if (obs() !== {16'd12, O_HELD}) $display("FAIL pause_enter: got %h expected %h", obs(), {16'd12, O_HELD});
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (obs() !== {16'd12, O_HELD}) $display("FAIL pause_hold%0d: got %h expected %h", i, obs(), {16'd12, O_HELD});
            else n_pass++;
        end
        pause = 0;
        #1;
        n_checks++;
        if (obs() !== {16'd12, O_WASH}) $display("FAIL pause_release: got %h expected %h", obs(), {16'd12, O_WASH});
        else n_pass++;
        for (int t = 11; t >= 1; t--) begin
            tick();
            n_checks++;
            if (obs() !== {16'(t), O_WASH | ((t == 1) ? P_CF : 16'h0)})
                $display("FAIL pause_resume t%0d: got %h expected %h", t, obs(), {16'(t), O_WASH | ((t == 1) ? P_CF : 16'h0)});
            else n_pass++;
        end
        tick();
        n_checks++;
        if (obs() !== {16'd5, O_DRAIN}) $display("FAIL pause_drain: got %h expected %h", obs(), {16'd5, O_DRAIN});
        else n_pass++;
        stop = 1; start = 0;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL stop_drain: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        stop = 0;
    endtask

    task automatic test_missing_detergent();
        idle_inputs();
        detergentfilled = 0;
        start = 1;
        #1;
        n_checks++;
        if (obs() !== {16'd0, O_ALARM}) $display("FAIL nodet_alarm: got %h expected %h", obs(), {16'd0, O_ALARM});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_ALARM}) $display("FAIL nodet_stay: got %h expected %h", obs(), {16'd0, O_ALARM});
        else n_pass++;
        start = 0;
        #1;
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL nodet_clear: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        tick();
    endtask

    task automatic test_dry();
        idle_inputs();
        dry = 1; detergentfilled = 0; start = 1;
        tick();
        dry = 0;
        for (int t = 15; t >= 1; t--) begin
            if (t != 15) tick();
            n_checks++;
            if (obs() !== {16'(t), O_DRY}) $display("FAIL dry t%0d: got %h expected %h", t, obs(), {16'(t), O_DRY});
            else n_pass++;
        end
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_DONE}) $display("FAIL dry_done: got %h expected %h", obs(), {16'd0, O_DONE});
        else n_pass++;
        start = 0;
        tick();
    endtask

    task automatic test_wash_only();
        logic [15:0] lens [3] = '{16'd5, 16'd20, 16'd5};
        logic [15:0] outs [3] = '{O_FILLW, O_WASH, O_DRAIN};
        logic [15:0] exp_o;
        idle_inputs();
        washOnly = 1; start = 1;
        tick();
        washOnly = 0;
        for (int p = 0; p < 3; p++) begin
            for (int t = int'(lens[p]); t >= 1; t--) begin
                if (!(p == 0 && t == 5)) tick();
                exp_o = outs[p] | ((p == 1 && t == 1) ? P_CF : 16'h0);
                n_checks++;
                if (obs() !== {16'(t), exp_o})
                    $display("FAIL washonly p%0d t%0d: got %h expected %h", p, t, obs(), {16'(t), exp_o});
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_DONE}) $display("FAIL washonly_done: got %h expected %h", obs(), {16'd0, O_DONE});
        else n_pass++;
        stop = 1;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL done_stop: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        stop = 0; start = 0;
        tick();
    endtask

    task automatic test_stop_rinse();
        idle_inputs();
        start = 1;
        for (int i = 0; i < 39; i++) tick();
        n_checks++;
        if (obs() !== {16'd7, O_RINSE}) $display("FAIL rinse_pre: got %h expected %h", obs(), {16'd7, O_RINSE});
        else n_pass++;
        stop = 1;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL stop_rinse: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL start_stop_idle: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        stop = 0; start = 0;
        tick();
    endtask

    task automatic test_reset_spin();
        idle_inputs();
        start = 1;
        for (int i = 0; i < 53; i++) tick();
        n_checks++;
        if (obs() !== {16'd8, O_SPIN}) $display("FAIL spin_pre: got %h expected %h", obs(), {16'd8, O_SPIN});
        else n_pass++;
        spinSpeed = 2'b00;
        #1;
        n_checks++;
        if (obs() !== {16'd8, 16'hD080}) $display("FAIL spin_speed0: got %h expected %h", obs(), {16'd8, 16'hD080});
        else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if (obs() !== {16'd0, O_IDLE}) $display("FAIL reset_spin: got %h expected %h", obs(), {16'd0, O_IDLE});
        else n_pass++;
        start = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_door();
        idle_inputs();
        start = 1;
        tick();
        tick();
        doorclosed = 0;
        #1;
        n_checks++;
        if (obs() !== {16'd4, O_DOOR}) $display("FAIL door_open: got %h expected %h", obs(), {16'd4, O_DOOR});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd4, O_DOOR}) $display("FAIL door_hold: got %h expected %h", obs(), {16'd4, O_DOOR});
        else n_pass++;
        doorclosed = 1;
        #1;
        n_checks++;
        if (obs() !== {16'd4, O_FILLW}) $display("FAIL door_close: got %h expected %h", obs(), {16'd4, O_FILLW});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd3, O_FILLW}) $display("FAIL door_resume: got %h expected %h", obs(), {16'd3, O_FILLW});
        else n_pass++;
        stop = 1;
        tick();
        stop = 0;
        doorclosed = 0;
        #1;
        n_checks++;
        if (obs() !== {16'd0, O_ALARM}) $display("FAIL door_start_alarm: got %h expected %h", obs(), {16'd0, O_ALARM});
        else n_pass++;
        tick();
        n_checks++;
        if (obs() !== {16'd0, O_ALARM}) $display("FAIL door_no_start: got %h expected %h", obs(), {16'd0, O_ALARM});
        else n_pass++;
        start = 0;
        doorclosed = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_pause();
        test_missing_detergent();
        test_dry();
        test_wash_only();
        test_stop_rinse();
        test_reset_spin();
        test_door();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/washing_machine_ctrl.md
Name:
washing_machine_ctrl

Overview:
- Cycle-sequencing controller for a front-load washing machine; sits between the user panel/sensors and the valve, heater and motor drivers.
- Runs a full wash program (fill+soap, wash, drain, fill, rinse, drain, spin), a wash-only program or a dry-only program.
- Supports pause, stop and safety alarms, and exposes a per-phase countdown timer.

Parameters:
- FILL_T, 5: fill phase length in clocks
- WASH_T, 20: wash phase length
- DRAIN_T, 5: drain phase length
- RINSE_T, 10: rinse phase length
- SPIN_T, 10: spin phase length
- DRY_T, 15: dry phase length
- All durations are 16-bit values and must be at least 1.

Ports:
- clk in 1: system clock, rising edge
- rst_n in 1: asynchronous, active-low reset
- start in 1: level request to run a program
- stop in 1: abort current program
- pause in 1: level; freeze current phase
- doorclosed in 1: door sensor, 1 = closed
- detergentfilled in 1: detergent present
- dry in 1: select dry-only program
- washOnly in 1: select wash-only program (ignored if dry=1)
- waterTemp in 2: heater level request
- spinSpeed in 2: spin speed request
- doorLock out 1: door lock solenoid
- motorStart out 1: drum motor enable
- motor_speed out 2: drum speed
- heater_on out 2: heater level
- fill_value_on out 1: water inlet valve
- soap_value_on out 1: detergent valve
- drain_value_on out 1: drain pump/valve
- soapWash out 1: in soap-wash phase
- waterWash out 1: in rinse phase
- cycleFinished out 1: 1-clock pulse at wash-phase end
- rinseFinished out 1: 1-clock pulse at rinse-phase end
- spinFinished out 1: 1-clock pulse at spin-phase end
- done out 1: program complete
- alarm out 1: fault indication
- timer out 16: remaining clocks in current phase

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including timer=0.
- States: IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DRY, DONE.
- Phase entry loads timer with the phase duration. Each unpaused clock decrements the timer. When timer==1 and not paused, the next edge enters the next phase. Each phase therefore lasts exactly its duration in clocks.
- Program sequences:
  - Normal: FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, DONE.
  - washOnly: FILL_W, WASH, DRAIN_W, DONE.
  - dry: DRY, DONE.
  - The mode is latched at start; later changes to dry or washOnly are ignored.
- IDLE start acceptance, evaluated on each edge with start=1:
  - dry=1: accepted if doorclosed=1.
  - dry=0: accepted if doorclosed=1 and detergentfilled=1.
  - Otherwise alarm=1 and the block stays in IDLE.
  - alarm clears in IDLE once start=0 or the failing condition clears.
- Phase outputs (all outputs not listed are 0):
  - FILL_W: fill_value_on=1, soap_value_on=1.
  - WASH: motorStart=1, motor_speed=01, soapWash=1, heater_on=waterTemp (sampled live).
  - FILL_R: fill_value_on=1.
  - RINSE: motorStart=1, motor_speed=01, waterWash=1.
  - DRAIN_W and DRAIN_R: drain_value_on=1.
  - SPIN: motorStart=1, drain_value_on=1, motor_speed=spinSpeed, with 00 mapped to 01.
  - DRY: motorStart=1, motor_speed=10, heater_on=11.
- doorLock=1 in every state except IDLE and DONE.
- Finish pulses: cycleFinished, rinseFinished and spinFinished are high for exactly the last clock of WASH, RINSE and SPIN respectively (the cycle where timer==1 and not paused).
- DONE: done=1, timer=0. Returns to IDLE on the edge where start=0 or stop=1.
- Pause, in any running phase: state and timer hold. motorStart, motor_speed, heater_on, all valves and finish pulses are forced to 0; doorLock stays 1. Release resumes with the same timer value.
- Door open while running (doorclosed=0 outside IDLE/DONE): alarm=1 and behaviour identical to pause. Alarm clears and the phase resumes when the door closes.
- Stop: synchronous; stop=1 in any state goes to IDLE on the next edge with all outputs 0. stop has priority over pause, door and timer expiry.
- Simultaneous start and stop in IDLE: stop wins and the block stays in IDLE.
- Timer is 16-bit unsigned and never wraps: it is loaded only at phase entry and stops at 1 before transition.

Test Plan:
- Normal program: doorclosed=1, detergentfilled=1, start=1, waterTemp=01, spinSpeed=10. Response: FILL_W for 5 clocks with fill and soap valves on; WASH for 20 clocks with heater_on=01 and cycleFinished pulse at the end; rinseFinished pulse at clock 45; SPIN with motor_speed=10; spinFinished pulse at clock 60; then done=1 with doorLock=0.
- Pause mid-WASH at timer=12 for 6 clocks: timer holds 12, motorStart=0, doorLock=1. After release, WASH completes 12 clocks later.
- Missing detergent: start=1, detergentfilled=0. Response: alarm=1, state IDLE, doorLock=0. Dropping start clears alarm.
- Dry-only: dry=1, detergentfilled=0, start=1. Response: DRY for 15 clocks with motor_speed=10 and heater_on=11, no valves active, then done=1.
- Wash-only: washOnly=1. Response: FILL_W, WASH, DRAIN_W, then done after 30 clocks; rinseFinished and spinFinished never assert.
- Stop mid-RINSE, and rst_n=0 mid-SPIN: all outputs 0 (stop on the next edge, reset immediately); state IDLE; no start while doorclosed=0.
